// File: rtl/dma_copy.sv
// Word-by-word memory copy engine: read, capture, write per word, with a running sum of copied data.
// Latency 3 cycles per word plus one DONE cycle; no backpressure, start is only honoured in IDLE.
module dma_copy (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  src,
  input  logic [4:0]  dst,
  input  logic [5:0]  len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] sum,
  output logic        cen,
  output logic        wen,
  output logic [4:0]  addr,
  output logic [31:0] din,
  input  logic [31:0] dout
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  src_q;
  logic [4:0]  dst_q;
  logic [5:0]  len_q;
  logic [4:0]  idx;
  logic [31:0] data_buf;
  logic [31:0] sum_q;
  logic        err_q;
  logic        len_ok;
  logic        last_word;

  assign len_ok    = (len != 6'd0) && (len <= 6'd32);
  // len_q is at least 1 whenever the copy loop runs, so idx + 1 never exceeds 32
  assign last_word = ({1'b0, idx} + 6'd1) == len_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = len_ok ? RD : DONE;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = WR;
      WR:      state_nxt = last_word ? DONE : RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= 5'd0;
      dst_q    <= 5'd0;
      len_q    <= 6'd0;
      idx      <= 5'd0;
      data_buf <= 32'd0;
      sum_q    <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum_q <= 32'd0;
            err_q <= (len > 6'd32);
            if (len_ok) begin
              src_q <= src;
              dst_q <= dst;
              len_q <= len;
              idx   <= 5'd0;
            end
          end
        end
        CAP: begin
          data_buf <= dout;
          sum_q    <= sum_q + dout;
        end
        WR: begin
          if (!last_word) begin
            idx <= idx + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode registered state only; 5-bit adds wrap the address modulo 32
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    cen  = 1'b0;
    wen  = 1'b0;
    addr = 5'd0;
    din  = 32'd0;
    case (state)
      RD: begin
        busy = 1'b1;
        cen  = 1'b1;
        addr = src_q + idx;
      end
      CAP: begin
        busy = 1'b1;
      end
      WR: begin
        busy = 1'b1;
        cen  = 1'b1;
        wen  = 1'b1;
        addr = dst_q + idx;
        din  = data_buf;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign err = err_q;
  assign sum = sum_q;

endmodule

// File: tb/tb_dma_copy.sv
// Bench for dma_copy: behavioural 32-word memory, sequential copy model and per-cycle access schedule.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  src;
  logic [4:0]  dst;
  logic [5:0]  len;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] sum;
  logic        cen;
  logic        wen;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  always #5 clk = ~clk;

  dma_copy dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .src   (src),
    .dst   (dst),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .sum   (sum),
    .cen   (cen),
    .wen   (wen),
    .addr  (addr),
    .din   (din),
    .dout  (dout)
  );

  // Synchronous memory: read data appears the cycle after the access, 0 otherwise
  logic [31:0] mem      [32];
  logic [31:0] init_mem [32];
  logic        load = 1'b0;

  always @(posedge clk) begin
    if (load) mem <= init_mem;
    else if (cen && wen) mem[addr] <= din;
    dout <= (cen && !wen && !load) ? mem[addr] : 32'd0;
  end

  int vec_cnt     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] exp_mem [32];
  logic [31:0] exp_sum;
  logic        exp_err;
  logic [4:0]  rd_a [32];
  logic [4:0]  wr_a [32];
  logic [31:0] wdat [32];

  task automatic model_copy(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l, input int r);
    int n;
    logic [31:0] v;
    exp_err = (l > 6'd32);
    n = exp_err ? 0 : int'(l);
    exp_sum = 32'd0;
    for (int i = 0; i < n; i++) begin
      rd_a[i] = 5'(int'(s) + i);
      wr_a[i] = 5'(int'(d) + i);
      v = exp_mem[rd_a[i]];
      wdat[i] = v;
      if (r < 0 || 3 * i + 3 <= r) exp_mem[wr_a[i]] = v;
      exp_sum = exp_sum + v;
    end
    if (r >= 0) begin
      exp_sum = 32'd0;
      exp_err = 1'b0;
    end
  endtask

  task automatic preload();
    for (int j = 0; j < 32; j++) exp_mem[j] = init_mem[j];
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // r >= 0: reset is sampled at the r-th edge after the start edge
  task automatic run_copy(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l, input int r);
    int t;
    int i;
    int ph;
    model_copy(s, d, l, r);
    t = (l > 6'd32) ? 0 : 3 * int'(l);
    @(negedge clk);
    start = 1'b1;
    src   = s;
    dst   = d;
    len   = l;
    @(posedge clk);
    for (int k = 0; k <= t + 1; k++) begin
      @(negedge clk);
      if (r >= 0 && k == r) begin
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cen", 32'(cen), 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        break;
      end
      if (k == t + 1) begin
        check("post_busy", 32'(busy), 32'd0);
        check("post_done", 32'(done), 32'd0);
        check("post_sum", sum, exp_sum);
        check("post_err", 32'(err), 32'(exp_err));
        start = 1'b0;
        break;
      end
      check("done", 32'(done), 32'(k == t));
      check("busy", 32'(busy), 32'(k < t));
      if (k < t) begin
        i  = k / 3;
        ph = k % 3;
        check("cen", 32'(cen), 32'(ph != 1));
        if (ph == 0) begin
          check("rd_wen", 32'(wen), 32'd0);
          check("rd_addr", 32'(addr), 32'(rd_a[i]));
        end else if (ph == 2) begin
          check("wr_wen", 32'(wen), 32'd1);
          check("wr_addr", 32'(addr), 32'(wr_a[i]));
          check("wr_din", din, wdat[i]);
        end
      end else begin
        check("done_cen", 32'(cen), 32'd0);
        check("done_err", 32'(err), 32'(exp_err));
        check("done_sum", sum, exp_sum);
      end
      // Junk on the request inputs while not in IDLE; it must have no effect
      start = (k == t) ? 1'b1 : 1'($urandom_range(0, 1));
      src   = 5'($urandom);
      dst   = 5'($urandom);
      len   = 6'($urandom);
      if (r >= 0 && k == r - 1) reset = 1'b1;
    end
    if (r < 0) begin
      repeat (2) @(negedge clk);
      check("hold_sum", sum, exp_sum);
      check("hold_err", 32'(err), 32'(exp_err));
    end
    for (int j = 0; j < 32; j++) check("mem", mem[j], exp_mem[j]);
  endtask

  logic [31:0] a_v, b_v, c_v, d_v, tot, keep2, keep3;
  logic [5:0]  rl;
  int          rt;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    src   = 5'd0;
    dst   = 5'd0;
    len   = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_sum", sum, 32'd0);
    check("reset_cen", 32'(cen), 32'd0);
    check("reset_wen", 32'(wen), 32'd0);
    check("reset_addr", 32'(addr), 32'd0);
    check("reset_din", din, 32'd0);
    reset = 1'b0;

    // Basic four-word copy
    for (int j = 0; j < 32; j++) init_mem[j] = $urandom;
    for (int j = 0; j < 4; j++) init_mem[j] = 32'(j + 1);
    preload();
    run_copy(5'd0, 5'd8, 6'd4, -1);
    check("basic_sum", sum, 32'd10);
    check("basic_err", 32'(err), 32'd0);
    for (int j = 0; j < 4; j++) check("basic_mem", mem[8 + j], 32'(j + 1));

    // Wrapping, overlapping copy that re-reads an overwritten word
    a_v = $urandom; b_v = $urandom; c_v = $urandom; d_v = $urandom;
    init_mem[30] = a_v; init_mem[31] = b_v; init_mem[0] = c_v; init_mem[1] = d_v;
    preload();
    run_copy(5'd30, 5'd1, 6'd4, -1);
    check("wrap_m1", mem[1], a_v);
    check("wrap_m2", mem[2], b_v);
    check("wrap_m3", mem[3], c_v);
    check("wrap_m4", mem[4], a_v);

    // Zero length and oversized length
    run_copy(5'd5, 5'd9, 6'd0, -1);
    check("len0_sum", sum, 32'd0);
    check("len0_err", 32'(err), 32'd0);
    run_copy(5'd3, 5'd4, 6'd40, -1);
    check("len40_err", 32'(err), 32'd1);
    check("len40_sum", sum, 32'd0);

    // Full-memory in-place copy
    for (int j = 0; j < 32; j++) init_mem[j] = $urandom;
    tot = 32'd0;
    for (int j = 0; j < 32; j++) tot = tot + init_mem[j];
    preload();
    run_copy(5'd0, 5'd0, 6'd32, -1);
    check("full_sum", sum, tot);

    // Reset in the capture cycle of word 2
    for (int j = 0; j < 32; j++) init_mem[j] = $urandom;
    keep2 = init_mem[18];
    keep3 = init_mem[19];
    preload();
    run_copy(5'd0, 5'd16, 6'd4, 8);
    check("rst_keep2", mem[18], keep2);
    check("rst_keep3", mem[19], keep3);

    // Random copies, some oversized, some cut short by reset
    for (int n = 0; n < 25; n++) begin
      rl = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
      rt = (rl <= 6'd32) ? 3 * int'(rl) : 0;
      if (rt > 0 && $urandom_range(0, 5) == 0)
        run_copy(5'($urandom), 5'($urandom), rl, int'($urandom_range(1, rt)));
      else
        run_copy(5'($urandom), 5'($urandom), rl, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
